// File: rtl/dmem_defs.sv
// Shared definitions for the data memory stage: store-size codes,
// timer register word offsets and timer reset values.
package dmem_defs;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] TMR_MTIME_LO = 2'd0;
  localparam logic [1:0] TMR_MTIME_HI = 2'd1;
  localparam logic [1:0] TMR_CMP_LO   = 2'd2;
  localparam logic [1:0] TMR_CMP_HI   = 2'd3;

  localparam logic [63:0] MTIME_RST    = 64'h0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/dmem_timer.sv
// Memory-mapped 64-bit machine timer: prescaler, mtime, mtimecmp, irq.
// Only instantiated when DATA_MEM_TIMER_EN is defined.
module dmem_timer
  import dmem_defs::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [31:0] wd,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [63:0]   mtime;
  logic [63:0]   mtime_next;
  logic [63:0]   cmp;
  logic [63:0]   cmp_next;
  logic          tick;

  always_comb begin
    tick       = (cnt == TERM);
    cnt_next   = tick ? '0 : cnt + 1'b1;
    mtime_next = mtime;
    cmp_next   = cmp;
    // A software write to mtime suppresses the tick on both halves.
    if (we && (sel == TMR_MTIME_LO)) begin
      mtime_next[31:0] = wd;
    end else if (we && (sel == TMR_MTIME_HI)) begin
      mtime_next[63:32] = wd;
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
    if (we && (sel == TMR_CMP_LO)) cmp_next[31:0] = wd;
    if (we && (sel == TMR_CMP_HI)) cmp_next[63:32] = wd;
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      TMR_MTIME_LO: rdata = mtime[31:0];
      TMR_MTIME_HI: rdata = mtime[63:32];
      TMR_CMP_LO:   rdata = cmp[31:0];
      TMR_CMP_HI:   rdata = cmp[63:32];
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      mtime <= MTIME_RST;
      cmp   <= MTIMECMP_RST;
      irq   <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      mtime <= mtime_next;
      cmp   <= cmp_next;
      irq   <= (mtime_next >= cmp_next);
    end
  end

endmodule

// File: rtl/data_mem.sv
// Data memory stage: word RAM with store lane alignment, misalign check,
// optional machine timer window (enabled by DATA_MEM_TIMER_EN).
module data_mem
  import dmem_defs::*;
#(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] TIMER_BASE = 32'h0000_8000,
  parameter int          PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        store_misaligned,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   lanes;
  logic          bad;
  logic          wr_ok;
  logic          ram_hit;
  logic          tmr_hit;
  logic [31:0]   tmr_rd;

  assign widx    = addr[AW+1:2];
  assign ram_hit = ({1'b0, addr} < RAM_BYTES);
  assign tmr_hit = (addr[31:4] == TIMER_BASE[31:4]);

  always_comb begin
    be    = '0;
    lanes = wd;
    bad   = 1'b0;
    case (mem_ctrl)
      MEM_B: begin
        be    = 4'b0001 << addr[1:0];
        lanes = {4{wd[7:0]}};
      end
      MEM_H: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        lanes = {2{wd[15:0]}};
        bad   = addr[0];
      end
      MEM_W: begin
        be  = 4'b1111;
        bad = |addr[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  assign store_misaligned = mem_we && bad;
  assign wr_ok            = mem_we && !bad;

  // Reset held at the edge discards the store in flight.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd = '0;
    if (ram_hit)      rd = mem[widx];
    else if (tmr_hit) rd = tmr_rd;
  end

`ifdef DATA_MEM_TIMER_EN
  logic tmr_we;

  assign tmr_we = wr_ok && tmr_hit && (mem_ctrl == MEM_W);

  dmem_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (tmr_we),
    .sel   (addr[3:2]),
    .wd    (wd),
    .rdata (tmr_rd),
    .irq   (timer_irq)
  );
`else
  assign tmr_rd    = '0;
  assign timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed lane/misalign/unmapped cases, then random
// traffic against a byte-addressed little-endian memory model.
module tb_data_mem;

  localparam logic [31:0] TB = 32'h0000_8000;
  localparam int REG = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_we;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        store_misaligned;
  logic        timer_irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mb [REG];

  always #5 clk = ~clk;

  data_mem dut (
    .clk              (clk),
    .reset            (reset),
    .mem_we           (mem_we),
    .mem_ctrl         (mem_ctrl),
    .addr             (addr),
    .wd               (wd),
    .rd               (rd),
    .store_misaligned (store_misaligned),
    .timer_irq        (timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] c);
    return (c == 3'd0) ? 1 : (c == 3'd1) ? 2 : 4;
  endfunction

  function automatic logic mis_of(input logic we, input logic [2:0] c,
                                  input logic [31:0] a);
    if (!we) return 1'b0;
    if (c > 3'd2) return 1'b1;
    return (a % size_of(c)) != 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int w;
    if (a >= REG) return 32'h0;
    w = int'(a) & ~3;
    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
  endfunction

  task automatic step(input logic we, input logic [2:0] c,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit crd);
    logic m;
    @(negedge clk);
    mem_we = we; mem_ctrl = c; addr = a; wd = d;
    #1;
    m = mis_of(we, c, a);
    chk("misaligned", 32'(store_misaligned), 32'(m));
    if (crd) chk("rd", rd, exp_rd(a));
`ifndef DATA_MEM_TIMER_EN
    chk("irq_off", 32'(timer_irq), 32'h0);
`endif
    @(posedge clk);
    if (we && !m && a < REG) begin
      for (int k = 0; k < size_of(c); k++) mb[int'(a) + k] = d[8*k +: 8];
    end
  endtask

  task automatic peek(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  c;
    logic [31:0] got;
    bit          seen;
    int          r;
    reset = 1'b1; mem_we = 1'b0; mem_ctrl = 3'd2; addr = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", 32'(timer_irq), 32'h0);
    chk("rst_mis", 32'(store_misaligned), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < REG / 4; i++) step(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0);

    step(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    peek("t1_rd", 32'hDEAD_BEEF);
    step(1'b1, 3'd2, 32'h10, 32'h1122_3344, 1'b1);
    step(1'b1, 3'd0, 32'h13, 32'h0000_00A5, 1'b1);
    peek("t2_sb", 32'hA522_3344);
    step(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, 1'b1);
    peek("t2_sh", 32'hBEEF_3344);
    step(1'b1, 3'd2, 32'h11, 32'h5555_5555, 1'b1);
    peek("t3_sw_word", 32'hBEEF_3344);
    chk("t3_sw_mis", 32'(store_misaligned), 32'h1);
    step(1'b1, 3'd1, 32'h13, 32'h0000_7777, 1'b1);
    peek("t3_sh_word", 32'hBEEF_3344);
    chk("t3_sh_mis", 32'(store_misaligned), 32'h1);
    step(1'b1, 3'd2, 32'd4096, 32'hCAFE_F00D, 1'b1);
    peek("t6_oob", 32'h0);
`ifndef DATA_MEM_TIMER_EN
    step(1'b1, 3'd2, TB, 32'h1234_5678, 1'b1);
    peek("t6_win", 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, REG - 1));
      else if (r == 7) a = 32'd4096 + 32'($urandom_range(0, 15));
`ifndef DATA_MEM_TIMER_EN
      else if (r == 8) a = TB + 32'($urandom_range(0, 15));
`endif
      else             a = 32'h0001_0000 | ($urandom & 32'h7FFF_FFFF);
      c = 3'($urandom_range(0, 9));
      if ($urandom_range(0, 9) > 7) c = 3'd2;
      step(1'($urandom_range(0, 1)), c, a, $urandom, 1'b1);
    end

    @(negedge clk);
    reset = 1'b1; mem_we = 1'b1; mem_ctrl = 3'd2; addr = 32'h10; wd = 32'h0;
    @(posedge clk);
    @(negedge clk);
    mem_we = 1'b0;
    #1;
    chk("rst_ram_kept", rd, exp_rd(32'h10));
    chk("rst_mid_irq", 32'(timer_irq), 32'h0);
`ifdef DATA_MEM_TIMER_EN
    addr = TB;
    #1;
    chk("rst_mtime", rd, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

`ifdef DATA_MEM_TIMER_EN
    step(1'b1, 3'd2, TB + 4, 32'h0, 1'b0);
    step(1'b1, 3'd2, TB, 32'h0, 1'b0);
    step(1'b1, 3'd2, TB + 12, 32'h0, 1'b0);
    step(1'b1, 3'd2, TB + 8, 32'd5, 1'b0);
    seen = 1'b0; got = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      mem_we = 1'b0; addr = TB;
      #1;
      if (timer_irq) begin seen = 1'b1; got = rd; end
    end
    chk("irq_seen", 32'(seen), 32'h1);
    chk("irq_at_mtime", got, 32'd5);
    step(1'b1, 3'd2, TB + 8, 32'hFFFF_FFFF, 1'b0);
    #1;
    chk("irq_fall", 32'(timer_irq), 32'h0);
    step(1'b1, 3'd2, TB + 4, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 3'd2, TB, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    mem_we = 1'b0; addr = TB;
    #1;
    chk("wrap_lo_pre", rd, 32'hFFFF_FFFF);
    addr = TB + 4;
    #1;
    chk("wrap_hi_pre", rd, 32'hFFFF_FFFF);
    @(negedge clk);
    addr = TB;
    #1;
    chk("wrap_lo", rd, 32'h0);
    addr = TB + 4;
    #1;
    chk("wrap_hi", rd, 32'h0);
    chk("wrap_irq", 32'(timer_irq), 32'h0);
`endif

    for (int i = 0; i < REG / 4; i++) begin
      @(negedge clk);
      mem_we = 1'b0; addr = 32'(i * 4);
      #1;
      chk("sweep", rd, exp_rd(addr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
